cfg_cmd_engine: RTL and testbench
=================================

# cfg_cmd_engine

Parametrised configuration-command engine for the SpaceWire router. It arbitrates round-robin among PORTNUM input buffers and parses WRITE, READ and REQ_ID command packets. It executes them against an NREG×DW register file, with a checked error path and a per-byte receive timeout, and returns a reply packet through the external output buffer. It sits between the port input buffers, the external port and the control/status consumers in the switch.

## Interface
- PORTNUM, 16, number of input buffers arbitrated
- DW, 32, register width; multiple of 8
- NREG, 16, register count (≥3, ≤256)
- ROUTER_ID, 32'h0000_0001, value of read-only reg 0
- TIMEOUT, 1023, idle cycles allowed between bytes inside a packet

Ports:
- gclk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_data_i  in  PORTNUM*9  first-word-fall-through data; port p at [9p+8:9p]; bit8 = control flag
- empty_i  in  PORTNUM  input buffer empty flags
- rd_o  out  PORTNUM  one-hot read strobe; byte consumed in the same cycle
- out_data_o  out  9  reply byte
- we_o  out  1  reply write strobe
- full_i  in  1  external output buffer full
- cfg_regs_o  out  NREG*DW  flat register file; reg r at [DW*r+DW-1:DW*r]
- cfg_wrbusy_o  out  1  high from DATA entry until the write commits
- cfg_int_o  out  1  one-cycle pulse per committed write or error reply

## Operation
- Control bytes: EOP = 9'h100, EEP = 9'h101. Commands: WRITE = 8'h01, READ = 8'h02, REQ_ID = 8'h03.
- Status codes: OK = 00, BADCMD = 01, BADADDR = 02, EARLY_END = 03, TIMEOUT = 04.
- Request format: cmd, addr, then DW/8 data bytes (WRITE only, MSB first), then EOP.
- Reply format: status, cmd, addr, then DW/8 data bytes (OK only), then EOP.
- Reply data by command: READ returns the register; REQ_ID returns ROUTER_ID; WRITE echoes the written value.
- Register map: reg0 = ROUTER_ID (RO). reg1 = error counter (RO, saturating, +1 per non-OK reply). reg2..NREG-1 are RW, reset to 0.
- FSM states: IDLE → HDR → ADDR → DATA → TAIL → EXEC → REPLY → IDLE. DISCARD → REPLY.
- IDLE: grant the lowest-index non-empty port, searching cyclically from last_grant+1. Hold that grant until the packet ends.
- HDR: a control byte is dropped silently and the FSM returns to IDLE. An unknown cmd sets BADCMD and goes to DISCARD.
- ADDR: addr ≥ NREG, or WRITE to reg0 or reg1, sets BADADDR and goes to DISCARD. Otherwise go to DATA (WRITE) or TAIL.
- DATA/TAIL: EOP or EEP before the expected position sets EARLY_END and goes to REPLY (no drain). TAIL: a data byte where EOP is expected sets EARLY_END and goes to DISCARD; EEP in TAIL also gives EARLY_END.
- DISCARD: consume bytes until EOP or EEP, then go to REPLY.
- EXEC: commit the WRITE, pulse cfg_int_o, then go to REPLY.
- Timeout: a counter runs in HDR…TAIL and DISCARD, clears on each consumed byte, and on reaching TIMEOUT sets TIMEOUT status and goes to REPLY. Leftover bytes are handled later as new packets.
- Error reply: cfg_int_o pulses in the first REPLY cycle, and reg1 increments once (holds at all-ones).

## Timing
- Reset values: rd_o = 0, we_o = 0, out_data_o = 0, cfg_wrbusy_o = 0, cfg_int_o = 0. Registers reset to 0 except reg0. Arbiter pointer resets to PORTNUM-1, so port 0 wins first.
- rd_o is combinational: granted bit = consuming state & !empty_i[grant]. All other outputs are registered.
- Grant: one IDLE cycle, then HDR on the next clock. Minimum WRITE latency is IDLE→EXEC = 4+DW/8 cycles with no stalls.
- A write is visible on cfg_regs_o in the cycle after EXEC.
- REPLY: we_o = !full_i with out_data_o valid. The byte index advances only when we_o is high. full_i stalls indefinitely; no timeout applies in REPLY.
- After reply EOP, the FSM is in IDLE the next cycle.
- Reset mid-packet or mid-reply: return to IDLE immediately. A partial reply is abandoned without EOP, and the input remainder is parsed as new packets.

## Structure
- Package cfg_pkg: EOP/EEP, command codes, status codes, state enum.
- Sub-module cfg_rr_arbiter (PORTNUM): inputs req and advance; output one-hot grant and index; holds a last-grant pointer.

## Test plan
- Port 3 sends 01,05,DE,AD,BE,EF,EOP → reg5 = DEADBEEF; reply 00,01,05,DE,AD,BE,EF,EOP; one cfg_int_o pulse.
- READ reg0 (02,00,EOP) → reply 00,02,00,00,00,00,01,EOP.
- WRITE to addr 01 → BADADDR; remaining bytes drained to EOP; reply 02,01,01,EOP; reg1 = 1.
- Ports 0, 5 and 9 all non-empty with READ packets → served in order 0, 5, 9, then 0 again.
- WRITE truncated by EEP after 2 data bytes → reply 03,01,addr,EOP; register unchanged.
- Stall after the addr byte for TIMEOUT cycles → reply 04,cmd,addr,EOP. Hold full_i for 50 cycles in REPLY → no bytes lost, no duplicate bytes.

Source files
------------

// File: rtl/cfg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cfg_pkg                                                       |
// | Purpose  : Shared constants, command/status codes and FSM state encoding |
// |            for the configuration-command engine.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package cfg_pkg;

  // Control bytes: bit 8 flags a control character
  localparam logic [8:0] c_eop = 9'h100;
  localparam logic [8:0] c_eep = 9'h101;

  // Command codes
  localparam logic [7:0] c_cmd_write  = 8'h01;
  localparam logic [7:0] c_cmd_read   = 8'h02;
  localparam logic [7:0] c_cmd_req_id = 8'h03;

  // Reply status codes
  localparam logic [7:0] c_st_ok        = 8'h00;
  localparam logic [7:0] c_st_badcmd    = 8'h01;
  localparam logic [7:0] c_st_badaddr   = 8'h02;
  localparam logic [7:0] c_st_early_end = 8'h03;
  localparam logic [7:0] c_st_timeout   = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA    = 3'd3,
    ST_TAIL    = 3'd4,
    ST_EXEC    = 3'd5,
    ST_REPLY   = 3'd6,
    ST_DISCARD = 3'd7
  } cfg_state_t;

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == c_cmd_write) || (cmd == c_cmd_read) || (cmd == c_cmd_req_id);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cfg_rr_arbiter                                                |
// | Purpose  : Round-robin arbiter; grants the lowest-index requester found  |
// |            searching cyclically from last_grant+1.                       |
// | Ports    : clk, reset (sync, active-low), req[PORTNUM], advance          |
// |            grant[PORTNUM] one-hot, grant_idx, grant_valid                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cfg_rr_arbiter #(
  parameter int PORTNUM = 16,
  parameter int PW      = (PORTNUM > 1) ? $clog2(PORTNUM) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PORTNUM-1:0] req,
  input  logic               advance,
  output logic [PORTNUM-1:0] grant,
  output logic [PW-1:0]      grant_idx,
  output logic               grant_valid
);

  logic [PW-1:0] last_q, last_d;
  int            cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int k = 1; k <= PORTNUM; k++) begin
      cand = int'(last_q) + k;
      if (cand >= PORTNUM) cand = cand - PORTNUM;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    last_d = last_q;
    if (advance && grant_valid) last_d = grant_idx;
  end

  // Pointer starts at the top port so port 0 wins the first arbitration
  always_ff @(posedge clk) begin
    if (!reset) last_q <= PW'(PORTNUM - 1);
    else        last_q <= last_d;
  end

endmodule
`default_nettype wire

// File: rtl/cfg_cmd_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cfg_cmd_engine                                                |
// | Purpose  : Configuration-command engine. Arbitrates PORTNUM input        |
// |            buffers, parses WRITE/READ/REQ_ID packets, executes them on   |
// |            an NREG x DW register file and emits a reply packet.          |
// | Ports    : gclk, reset (sync, active-low)                                |
// |            in_data_i/empty_i/rd_o  - FWFT input buffers (9 bits/port)    |
// |            out_data_o/we_o/full_i  - reply output buffer                 |
// |            cfg_regs_o              - flat register file                  |
// |            cfg_wrbusy_o/cfg_int_o  - write busy, commit/error pulse      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cfg_cmd_engine
  import cfg_pkg::*;
#(
  parameter int              PORTNUM   = 16,
  parameter int              DW        = 32,
  parameter int              NREG      = 16,
  parameter logic [DW-1:0]   ROUTER_ID = 'h0000_0001,
  parameter int              TIMEOUT   = 1023
) (
  input  logic                 gclk,
  input  logic                 reset,
  input  logic [PORTNUM*9-1:0] in_data_i,
  input  logic [PORTNUM-1:0]   empty_i,
  output logic [PORTNUM-1:0]   rd_o,
  output logic [8:0]           out_data_o,
  output logic                 we_o,
  input  logic                 full_i,
  output logic [NREG*DW-1:0]   cfg_regs_o,
  output logic                 cfg_wrbusy_o,
  output logic                 cfg_int_o
);

  localparam int NB = DW / 8;
  localparam int PW = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = $clog2(NB + 4);
  localparam int TW = $clog2(TIMEOUT + 1);

  cfg_state_t          state_q, state_d;
  logic [PW-1:0]       port_q, port_d;
  logic [PORTNUM-1:0]  port_oh_q, port_oh_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          status_q, status_d;
  logic [DW-1:0]       data_q, data_d;
  logic [CW-1:0]       bcnt_q, bcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                wrbusy_q, wrbusy_d;
  logic                int_q, int_d;
  logic                we_q, we_d;
  logic [8:0]          out_data_q, out_data_d;
  logic [DW-1:0]       regs_q [NREG];
  logic [DW-1:0]       regs_d [NREG];

  logic [PORTNUM-1:0]  arb_grant;
  logic [PW-1:0]       arb_idx;
  logic                arb_valid;
  logic                arb_advance;

  logic [8:0]          cur_byte;
  logic                consuming;
  logic                take;
  logic [8:0]          reply_byte;
  logic                reply_in_data;
  logic                reply_last;

  cfg_rr_arbiter #(
    .PORTNUM (PORTNUM),
    .PW      (PW)
  ) u_arb (
    .clk         (gclk),
    .reset       (reset),
    .req         (~empty_i),
    .advance     (arb_advance),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Head byte of the granted buffer
  always_comb begin
    cur_byte = '0;
    for (int p = 0; p < PORTNUM; p++) begin
      if (port_q == PW'(p)) cur_byte = in_data_i[9*p +: 9];
    end
  end

  assign consuming = (state_q == ST_HDR)  || (state_q == ST_ADDR) ||
                     (state_q == ST_DATA) || (state_q == ST_TAIL) ||
                     (state_q == ST_DISCARD);
  assign take      = consuming && |(port_oh_q & ~empty_i);
  assign rd_o      = take ? port_oh_q : '0;

  // Reply byte sequence: status, cmd, addr, [data MSB first], EOP.
  // data_q is shifted left as each data byte leaves, so the MSB is always next.
  assign reply_in_data = (status_q == c_st_ok) && (idx_q >= IW'(3)) && (idx_q < IW'(3 + NB));
  assign reply_last    = (status_q == c_st_ok) ? (idx_q == IW'(3 + NB)) : (idx_q == IW'(3));

  always_comb begin
    reply_byte = c_eop;
    if      (idx_q == IW'(0)) reply_byte = {1'b0, status_q};
    else if (idx_q == IW'(1)) reply_byte = {1'b0, cmd_q};
    else if (idx_q == IW'(2)) reply_byte = {1'b0, addr_q};
    else if (reply_in_data)   reply_byte = {1'b0, data_q[DW-1 -: 8]};
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    port_oh_d   = port_oh_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    status_d    = status_q;
    data_d      = data_q;
    bcnt_d      = bcnt_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    we_d        = 1'b0;
    out_data_d  = out_data_q;
    int_d       = 1'b0;
    regs_d      = regs_q;
    arb_advance = 1'b0;

    // Inter-byte timeout; any byte arriving in this cycle wins over it
    if (consuming) begin
      if (take) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        status_d = c_st_timeout;
        state_d  = ST_REPLY;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        cmd_d    = '0;
        addr_d   = '0;
        status_d = c_st_ok;
        bcnt_d   = '0;
        tmo_d    = '0;
        if (arb_valid) begin
          port_d      = arb_idx;
          port_oh_d   = arb_grant;
          arb_advance = 1'b1;
          state_d     = ST_HDR;
        end
      end

      ST_HDR: if (take) begin
        if (cur_byte[8]) begin
          state_d = ST_IDLE;           // stray end marker: drop silently
        end else begin
          cmd_d = cur_byte[7:0];
          if (is_known_cmd(cur_byte[7:0])) begin
            state_d = ST_ADDR;
          end else begin
            status_d = c_st_badcmd;
            state_d  = ST_DISCARD;
          end
        end
      end

      ST_ADDR: if (take) begin
        if (cur_byte[8]) begin
          status_d = c_st_early_end;
          state_d  = ST_REPLY;
        end else begin
          addr_d = cur_byte[7:0];
          if (({1'b0, cur_byte[7:0]} >= 9'(NREG)) ||
              ((cmd_q == c_cmd_write) && (cur_byte[7:1] == 7'd0))) begin
            status_d = c_st_badaddr;
            state_d  = ST_DISCARD;
          end else if (cmd_q == c_cmd_write) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_TAIL;
          end
        end
      end

      ST_DATA: if (take) begin
        if (cur_byte[8]) begin
          status_d = c_st_early_end;
          state_d  = ST_REPLY;
        end else begin
          data_d = (data_q << 8) | DW'(cur_byte[7:0]);
          if (bcnt_q == CW'(NB - 1)) state_d = ST_TAIL;
          else                       bcnt_d  = bcnt_q + CW'(1);
        end
      end

      ST_TAIL: if (take) begin
        if (cur_byte == c_eop) begin
          if (cmd_q == c_cmd_write) begin
            state_d = ST_EXEC;
          end else begin
            data_d  = (cmd_q == c_cmd_read) ? regs_q[addr_q[AW-1:0]] : ROUTER_ID;
            state_d = ST_REPLY;
          end
        end else if (cur_byte[8]) begin
          status_d = c_st_early_end;
          state_d  = ST_REPLY;
        end else begin
          status_d = c_st_early_end;
          state_d  = ST_DISCARD;
        end
      end

      ST_EXEC: begin
        regs_d[addr_q[AW-1:0]] = data_q;
        state_d = ST_REPLY;
      end

      ST_DISCARD: if (take && cur_byte[8]) state_d = ST_REPLY;

      ST_REPLY: if (!full_i) begin
        we_d       = 1'b1;
        out_data_d = reply_byte;
        idx_d      = idx_q + IW'(1);
        if (reply_in_data) data_d = data_q << 8;
        if (reply_last)    state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // First REPLY cycle: interrupt for commits and errors; errors also
    // bump the saturating error counter in reg1.
    if ((state_q != ST_REPLY) && (state_d == ST_REPLY)) begin
      idx_d = '0;
      if (status_d != c_st_ok) begin
        int_d = 1'b1;
        if (regs_q[1] != {DW{1'b1}}) regs_d[1] = regs_q[1] + DW'(1);
      end else if (state_q == ST_EXEC) begin
        int_d = 1'b1;
      end
    end
  end

  assign wrbusy_d = (cmd_d == c_cmd_write) &&
                    ((state_d == ST_DATA) || (state_d == ST_TAIL) || (state_d == ST_EXEC));

  always_ff @(posedge gclk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      port_q     <= '0;
      port_oh_q  <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      status_q   <= c_st_ok;
      data_q     <= '0;
      bcnt_q     <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      wrbusy_q   <= 1'b0;
      int_q      <= 1'b0;
      we_q       <= 1'b0;
      out_data_q <= '0;
      for (int r = 0; r < NREG; r++) regs_q[r] <= (r == 0) ? ROUTER_ID : '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      port_oh_q  <= port_oh_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      status_q   <= status_d;
      data_q     <= data_d;
      bcnt_q     <= bcnt_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      wrbusy_q   <= wrbusy_d;
      int_q      <= int_d;
      we_q       <= we_d;
      out_data_q <= out_data_d;
      regs_q     <= regs_d;
    end
  end

  generate
    for (genvar r = 0; r < NREG; r++) begin : g_regs_flat
      assign cfg_regs_o[DW*r +: DW] = regs_q[r];
    end
  endgenerate

  assign out_data_o   = out_data_q;
  assign we_o         = we_q;
  assign cfg_wrbusy_o = wrbusy_q;
  assign cfg_int_o    = int_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_cmd_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cfg_cmd_engine                                             |
// | Purpose  : Self-checking bench for cfg_cmd_engine with FWFT input FIFO   |
// |            models and a reply scoreboard.                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cfg_cmd_engine;

  localparam int NP   = 16;
  localparam int DW   = 32;
  localparam int NREG = 16;
  localparam int TMO  = 1023;
  localparam logic [8:0] EOP = 9'h100;
  localparam logic [8:0] EEP = 9'h101;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*9-1:0]   in_data_i;
  logic [NP-1:0]     empty_i;
  logic [NP-1:0]     rd_o;
  logic [8:0]        out_data_o;
  logic              we_o;
  logic              full_i;
  logic [NREG*DW-1:0] cfg_regs_o;
  logic              cfg_wrbusy_o;
  logic              cfg_int_o;

  cfg_cmd_engine #(
    .PORTNUM   (NP),
    .DW        (DW),
    .NREG      (NREG),
    .ROUTER_ID (32'h0000_0001),
    .TIMEOUT   (TMO)
  ) dut (
    .gclk         (clk),
    .reset        (reset),
    .in_data_i    (in_data_i),
    .empty_i      (empty_i),
    .rd_o         (rd_o),
    .out_data_o   (out_data_o),
    .we_o         (we_o),
    .full_i       (full_i),
    .cfg_regs_o   (cfg_regs_o),
    .cfg_wrbusy_o (cfg_wrbusy_o),
    .cfg_int_o    (cfg_int_o)
  );

  always #5 clk = ~clk;

  logic [8:0] fifo [NP][$];
  logic [8:0] exp_q [$];
  logic [NP-1:0] rd_seen = '0;

  int n_checks   = 0;
  int n_fail     = 0;
  int int_cnt    = 0;
  int exp_int    = 0;
  int extra_cnt  = 0;
  int bad_rd     = 0;
  int we_in_full = 0;
  bit full_window = 1'b0;
  bit busy_seen   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_of(input int r);
    return cfg_regs_o[DW*r +: DW];
  endfunction

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (fifo[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // FWFT buffer model: pop what the DUT read at the last edge, present heads
  always @(negedge clk) begin
    logic [8:0] tmp;
    for (int p = 0; p < NP; p++)
      if (rd_seen[p] && fifo[p].size() > 0) tmp = fifo[p].pop_front();
    for (int p = 0; p < NP; p++) begin
      if (fifo[p].size() > 0) begin
        in_data_i[9*p +: 9] = fifo[p][0];
        empty_i[p]          = 1'b0;
      end else begin
        in_data_i[9*p +: 9] = '0;
        empty_i[p]          = 1'b1;
      end
    end
    #1;
    rd_seen = rd_o;
    if ((rd_o & empty_i) != '0) bad_rd++;
    if ($countones(rd_o) > 1)   bad_rd++;
  end

  // Reply monitor / scoreboard
  always @(negedge clk) begin
    if (cfg_int_o)    int_cnt++;
    if (cfg_wrbusy_o) busy_seen = 1'b1;
    if (we_o) begin
      if (full_window) we_in_full++;
      if (exp_q.size() == 0) extra_cnt++;
      else check_eq("reply_byte", {55'd0, out_data_o}, {55'd0, exp_q.pop_front()});
    end
  end

  task automatic push_byte(input int p, input logic [8:0] b);
    fifo[p].push_back(b);
  endtask

  task automatic send_write(input int p, input logic [7:0] a, input logic [31:0] d);
    push_byte(p, 9'h001);
    push_byte(p, {1'b0, a});
    for (int i = 3; i >= 0; i--) push_byte(p, {1'b0, d[8*i +: 8]});
    push_byte(p, EOP);
  endtask

  task automatic send_cmd(input int p, input logic [7:0] c, input logic [7:0] a);
    push_byte(p, {1'b0, c});
    push_byte(p, {1'b0, a});
    push_byte(p, EOP);
  endtask

  task automatic expect_reply(input logic [7:0] st, input logic [7:0] c,
                              input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({1'b0, st});
    exp_q.push_back({1'b0, c});
    exp_q.push_back({1'b0, a});
    if (st == 8'h00) for (int i = 3; i >= 0; i--) exp_q.push_back({1'b0, d[8*i +: 8]});
    exp_q.push_back(EOP);
    if (st != 8'h00) exp_int++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !all_empty()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {63'd0, n < budget}, 64'd1);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang, expected completion");
    $fatal(1);
  end

  initial begin
    reset  = 1'b0;
    full_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rd",      {48'd0, rd_o},       64'd0);
    check_eq("rst_we",      {63'd0, we_o},       64'd0);
    check_eq("rst_out",     {55'd0, out_data_o}, 64'd0);
    check_eq("rst_wrbusy",  {63'd0, cfg_wrbusy_o}, 64'd0);
    check_eq("rst_int",     {63'd0, cfg_int_o},  64'd0);
    check_eq("rst_reg0",    {32'd0, reg_of(0)},  64'h1);
    check_eq("rst_reg5",    {32'd0, reg_of(5)},  64'h0);
    reset = 1'b1;
    @(negedge clk);

    // WRITE reg5 from port 3
    busy_seen = 1'b0;
    expect_reply(8'h00, 8'h01, 8'h05, 32'hDEAD_BEEF);
    exp_int++;
    send_write(3, 8'h05, 32'hDEAD_BEEF);
    wait_done("write_done", 200);
    check_eq("write_reg5",   {32'd0, reg_of(5)}, 64'hDEAD_BEEF);
    check_eq("write_int",    int_cnt, exp_int);
    check_eq("write_busy",   {63'd0, busy_seen}, 64'd1);

    // READ reg0
    busy_seen = 1'b0;
    expect_reply(8'h00, 8'h02, 8'h00, 32'h0000_0001);
    send_cmd(3, 8'h02, 8'h00);
    wait_done("read0_done", 200);
    check_eq("read_no_busy", {63'd0, busy_seen}, 64'd0);
    check_eq("read_no_int",  int_cnt, exp_int);

    // WRITE to read-only reg1: BADADDR, payload drained
    expect_reply(8'h02, 8'h01, 8'h01, 32'h0);
    send_write(3, 8'h01, 32'h1122_3344);
    wait_done("badaddr_done", 200);
    check_eq("badaddr_reg1", {32'd0, reg_of(1)}, 64'd1);
    check_eq("badaddr_int",  int_cnt, exp_int);

    // WRITE reg2 from port 10, leaving the arbiter pointer at 10
    expect_reply(8'h00, 8'h01, 8'h02, 32'h1234_5678);
    exp_int++;
    send_write(10, 8'h02, 32'h1234_5678);
    wait_done("write2_done", 200);
    check_eq("write_reg2", {32'd0, reg_of(2)}, 64'h1234_5678);

    // Round robin: ports 0, 5, 9 pending, port 0 has a second packet
    expect_reply(8'h00, 8'h02, 8'h05, 32'hDEAD_BEEF);
    expect_reply(8'h00, 8'h02, 8'h02, 32'h1234_5678);
    expect_reply(8'h00, 8'h02, 8'h01, 32'h0000_0001);
    expect_reply(8'h00, 8'h02, 8'h00, 32'h0000_0001);
    send_cmd(0, 8'h02, 8'h05);
    send_cmd(5, 8'h02, 8'h02);
    send_cmd(9, 8'h02, 8'h01);
    send_cmd(0, 8'h02, 8'h00);
    wait_done("rr_done", 400);

    // WRITE truncated by EEP after two data bytes
    expect_reply(8'h03, 8'h01, 8'h07, 32'h0);
    push_byte(2, 9'h001); push_byte(2, 9'h007);
    push_byte(2, 9'h0AA); push_byte(2, 9'h0BB); push_byte(2, EEP);
    wait_done("eep_done", 200);
    check_eq("eep_reg7", {32'd0, reg_of(7)}, 64'd0);
    check_eq("eep_reg1", {32'd0, reg_of(1)}, 64'd2);

    // Stall after addr byte: TIMEOUT reply; late EOP becomes a dropped packet
    expect_reply(8'h04, 8'h02, 8'h03, 32'h0);
    push_byte(4, 9'h002); push_byte(4, 9'h003);
    wait_done("timeout_done", TMO + 200);
    push_byte(4, EOP);
    wait_done("leftover_done", 100);
    check_eq("timeout_reg1", {32'd0, reg_of(1)}, 64'd3);

    // Output buffer full for a long stretch of REPLY
    full_i      = 1'b1;
    full_window = 1'b1;
    expect_reply(8'h00, 8'h02, 8'h05, 32'hDEAD_BEEF);
    send_cmd(6, 8'h02, 8'h05);
    repeat (60) @(negedge clk);
    check_eq("full_no_write", we_in_full, 0);
    full_i      = 1'b0;
    full_window = 1'b0;
    wait_done("full_done", 200);

    // Unknown command
    expect_reply(8'h01, 8'h07, 8'h00, 32'h0);
    send_cmd(1, 8'h07, 8'h05);
    wait_done("badcmd_done", 200);
    check_eq("badcmd_reg1", {32'd0, reg_of(1)}, 64'd4);

    // REQ_ID
    expect_reply(8'h00, 8'h03, 8'h00, 32'h0000_0001);
    send_cmd(12, 8'h03, 8'h00);
    wait_done("reqid_done", 200);

    check_eq("int_total",   int_cnt,   exp_int);
    check_eq("extra_bytes", extra_cnt, 0);
    check_eq("rd_protocol", bad_rd,    0);

    // Reset clears the RW registers and the error counter
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst2_reg5", {32'd0, reg_of(5)}, 64'd0);
    check_eq("rst2_reg1", {32'd0, reg_of(1)}, 64'd0);
    check_eq("rst2_reg0", {32'd0, reg_of(0)}, 64'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
